conv_layer_engine: RTL and testbench
====================================

Name: conv_layer_engine

Overview:
- Parametrised, self-sequencing 2-D convolution engine; successor to the fixed 8x8/3x3/6-lane convolution layer.
- Streams a square image in row-major order through a KERNEL_SIZE-row circular line buffer.
- Computes each output row on ARRAY_SIZE parallel MAC lanes over one or more column passes, and emits saturated signed fixed-point features with valid/ready backpressure.
- Sits between the pixel source (ROM or input interface) and the activation/pooling stages.

Parameters:
WIDTH, 16, signed fixed-point pixel/weight/feature width
FRAC_BITS, 8, fractional bits of the fixed-point format
KERNEL_SIZE, 3, square kernel side (K); legal range 2..IMAGE_SIZE
IMAGE_SIZE, 8, square input image side (N); output side O = N-K+1
ARRAY_SIZE, 4, parallel MAC lanes (A); passes per output row P = ceil(O/A)

Ports:
clk  in  1  clock; all logic rising-edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse; begins a frame; honoured only in IDLE
in_valid  in  1  pixel_in valid
in_ready  out  1  engine accepts a pixel this cycle
pixel_in  in  WIDTH  signed input pixel
w_wr_en  in  1  weight write strobe
w_addr  in  clog2(K*K)  weight index, ky*K+kx
w_data  in  WIDTH  signed weight
out_valid  out  1  feature beat valid
out_ready  in  1  downstream accepts beat
out_data  out  A*WIDTH  lane 0 in MSBs, lane A-1 in LSBs
out_mask  out  A  lane j bit set = lane j holds a real output column
out_row  out  clog2(O)  output row of current beat
out_col  out  clog2(O)  output column of lane 0
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after the last beat of a frame is accepted

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; all counters, line buffer and weight registers cleared; in_ready=0, out_valid=0, out_data=0, out_mask=0, out_row=0, out_col=0, busy=0, frame_done=0. Reset mid-frame aborts the frame; no partial output.
- Weights: w_wr_en writes w_data to weight[w_addr] in every state except COMPUTE; writes during COMPUTE are dropped. w_addr >= K*K is ignored.
- FSM:
  - IDLE: start -> FILL.
  - FILL: in_ready=1; accept pixels until K full rows are stored -> COMPUTE (pass 0, out row 0).
  - COMPUTE: in_ready=0; K*K cycles, one tap (ky,kx) per cycle, kx fastest -> EMIT.
  - EMIT: out_valid=1 and outputs held stable until out_ready.
    - On accept, if pass < P-1: pass+1 -> COMPUTE.
    - Else if out_row < O-1: -> ROW.
    - Else: frame_done pulse -> IDLE.
  - ROW: in_ready=1; accept exactly N pixels into the oldest buffer row (circular; top-row pointer advances by 1 mod K) -> COMPUTE with out_row+1, pass 0.
- Pixel handshake: transfer when in_valid&&in_ready; column counter wraps at N, write-row pointer wraps at K.
- MAC per lane j:
  - Column c = pass*A + j.
  - acc_j += buf[top+ky mod K][c+kx] * weight[ky*K+kx].
  - Products are 2*WIDTH signed; accumulator is 2*WIDTH+clog2(K*K) bits, cleared at COMPUTE entry.
  - Lane with c >= O: pixel forced to 0, mask bit 0, output 0.
- Output conversion: acc >>> FRAC_BITS (arithmetic), saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; registered on the COMPUTE->EMIT transition.
- Latency: out_valid rises K*K cycles after COMPUTE entry. out_col = pass*A.
- start outside IDLE ignored. in_valid while in_ready=0 has no effect.
- Totals: frame = N*N pixels in, O*P beats out.

Optional Feature:
Macro CONV_ENGINE_RELU_EN.
- Defined: after saturation, any negative lane value is replaced by 0 before registering; masked lanes stay 0.
- Undefined: signed saturated values pass unchanged.
- No port or timing difference.

Test Plan:
- Defaults; all weights 0x0100; 64 pixels 0x0100; out_ready=1 -> 12 beats (rows 0..5, out_col 0/4); pass-0 lanes 0x0900, mask 4'b1111; pass-1 mask 4'b0011, lanes 2-3 0x0000; frame_done one cycle after 12th accept; busy falls.
- Identity kernel (weight[4]=0x0100, rest 0); pixel[r][c]=(r*8+c)<<8 -> out[r][c]=((r+1)*8+c+1)<<8 for all 36 outputs.
- Saturation: weights 0x7FFF, pixels 0x7FFF -> lanes 0x7FFF; pixels 0x8000 -> lanes 0x8000 (0x0000 with CONV_ENGINE_RELU_EN).
- Backpressure: out_ready=0 for 5 cycles in EMIT -> out_valid, out_data, out_mask, out_row, out_col stable; in_ready=0; beat accepted on the first out_ready=1 cycle; totals unchanged.
- Weight write during COMPUTE (w_addr 0, 0x7FFF) -> result unchanged; same write in IDLE -> next frame uses it.
- Reset asserted mid-COMPUTE of row 3 -> after edge all outputs at reset values, state IDLE; reload weights, new frame -> correct 12 beats.

Source files
------------

// File: rtl/conv_layer_engine.sv
// conv_layer_engine: self-sequencing 2-D convolution engine.
// Streams a square image through a KERNEL_SIZE-row circular line buffer and
// computes one output row at a time on ARRAY_SIZE parallel MAC lanes, with
// one or more column passes per row and valid/ready output backpressure.
// Optional build macro CONV_ENGINE_RELU_EN clamps negative features to zero.
module conv_layer_engine #(
   parameter int WIDTH       = 16,
   parameter int FRAC_BITS   = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int IMAGE_SIZE  = 8,
   parameter int ARRAY_SIZE  = 4,
   localparam int OUT_SIZE   = IMAGE_SIZE - KERNEL_SIZE + 1,
   localparam int TAPS       = KERNEL_SIZE * KERNEL_SIZE,
   localparam int WADDR_W    = $clog2(TAPS),
   localparam int OUT_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             pixel_in,
   input  logic                         w_wr_en,
   input  logic [WADDR_W-1:0]           w_addr,
   input  logic [WIDTH-1:0]             w_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ARRAY_SIZE*WIDTH-1:0]  out_data,
   output logic [ARRAY_SIZE-1:0]        out_mask,
   output logic [OUT_W-1:0]             out_row,
   output logic [OUT_W-1:0]             out_col,
   output logic                         busy,
   output logic                         frame_done
);

   localparam int NUM_PASS = (OUT_SIZE + ARRAY_SIZE - 1) / ARRAY_SIZE;
   localparam int COL_W    = $clog2(IMAGE_SIZE);
   localparam int ROW_W    = $clog2(KERNEL_SIZE);
   localparam int PASS_W   = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1;
   localparam int PROD_W   = 2 * WIDTH;
   localparam int ACC_W    = PROD_W + $clog2(TAPS);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FILL    = 3'd1;
   localparam logic [2:0] S_COMPUTE = 3'd2;
   localparam logic [2:0] S_EMIT    = 3'd3;
   localparam logic [2:0] S_ROW     = 3'd4;

   localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(IMAGE_SIZE - 1);
   localparam logic [ROW_W-1:0]   LAST_KIDX = ROW_W'(KERNEL_SIZE - 1);
   localparam logic [WADDR_W-1:0] LAST_TAP  = WADDR_W'(TAPS - 1);
   localparam logic [PASS_W-1:0]  LAST_PASS = PASS_W'(NUM_PASS - 1);
   localparam logic [OUT_W-1:0]   LAST_OROW = OUT_W'(OUT_SIZE - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (WIDTH - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (WIDTH - 1)));

   logic [2:0]               r_state;
   logic [COL_W-1:0]         r_wrCol;
   logic [ROW_W-1:0]         r_wrRow;
   logic [ROW_W-1:0]         r_topRow;
   logic [ROW_W-1:0]         r_kx;
   logic [ROW_W-1:0]         r_ky;
   logic [WADDR_W-1:0]       r_tap;
   logic [PASS_W-1:0]        r_pass;
   logic [OUT_W-1:0]         r_outRow;
   logic                     r_frameDone;
   logic signed [WIDTH-1:0]  r_lineBuf [KERNEL_SIZE][IMAGE_SIZE];
   logic signed [WIDTH-1:0]  r_weight [TAPS];
   logic signed [ACC_W-1:0]  r_acc [ARRAY_SIZE];
   logic [ARRAY_SIZE*WIDTH-1:0] r_outData;
   logic [ARRAY_SIZE-1:0]    r_outMask;

   logic                     w_pixFire;
   logic                     w_lastCol;
   logic                     w_lastTap;
   logic                     w_enterCompute;
   logic [ROW_W-1:0]         w_rowSel;
   logic signed [WIDTH-1:0]  w_tapWeight;
   logic signed [WIDTH-1:0]  w_pix [ARRAY_SIZE];
   logic signed [PROD_W-1:0] w_prod [ARRAY_SIZE];
   logic signed [ACC_W-1:0]  w_accNext [ARRAY_SIZE];
   logic signed [ACC_W-1:0]  w_shifted [ARRAY_SIZE];
   logic [WIDTH-1:0]         w_laneOut [ARRAY_SIZE];
   logic [ARRAY_SIZE-1:0]    w_laneMask;

   assign in_ready   = (r_state == S_FILL) || (r_state == S_ROW);
   assign out_valid  = (r_state == S_EMIT);
   assign busy       = (r_state != S_IDLE);
   assign frame_done = r_frameDone;
   assign out_data   = r_outData;
   assign out_mask   = r_outMask;
   assign out_row    = r_outRow;
   assign out_col    = OUT_W'(int'(r_pass) * ARRAY_SIZE);

   assign w_pixFire = in_valid && in_ready;
   assign w_lastCol = (r_wrCol == LAST_COL);
   assign w_lastTap = (r_tap == LAST_TAP);
   // Accumulators restart whenever a new pass begins, whichever state leads there
   assign w_enterCompute = ((r_state == S_FILL) && w_pixFire && w_lastCol && (r_wrRow == LAST_KIDX))
                        || ((r_state == S_EMIT) && out_ready && (r_pass != LAST_PASS))
                        || ((r_state == S_ROW) && w_pixFire && w_lastCol);

   // Per-lane tap datapath: fetch pixel, multiply, accumulate, then scale and saturate
   always_comb begin
      int rowSum;
      int col;
      rowSum = int'(r_topRow) + int'(r_ky);
      if (rowSum >= KERNEL_SIZE) rowSum = rowSum - KERNEL_SIZE;
      w_rowSel    = ROW_W'(rowSum);
      w_tapWeight = r_weight[r_tap];
      w_laneMask  = '0;
      for (int j = 0; j < ARRAY_SIZE; j++) begin
         col = int'(r_pass) * ARRAY_SIZE + j;
         w_pix[j] = '0;
         if (col < OUT_SIZE) begin
            w_laneMask[j] = 1'b1;
            w_pix[j] = r_lineBuf[w_rowSel][COL_W'(col + int'(r_kx))];
         end
         w_prod[j]    = PROD_W'(w_pix[j]) * PROD_W'(w_tapWeight);
         w_accNext[j] = r_acc[j] + ACC_W'(w_prod[j]);
         w_shifted[j] = w_accNext[j] >>> FRAC_BITS;
         if (w_shifted[j] > SAT_MAX)      w_laneOut[j] = SAT_MAX[WIDTH-1:0];
         else if (w_shifted[j] < SAT_MIN) w_laneOut[j] = SAT_MIN[WIDTH-1:0];
         else                             w_laneOut[j] = w_shifted[j][WIDTH-1:0];
`ifdef CONV_ENGINE_RELU_EN
         if (w_laneOut[j][WIDTH-1]) w_laneOut[j] = '0;
`else
`endif
         if (!w_laneMask[j]) w_laneOut[j] = '0;
      end
   end

   // Frame sequencer: pixel write pointers, tap walk, pass/row bookkeeping
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wrCol     <= '0;
         r_wrRow     <= '0;
         r_topRow    <= '0;
         r_kx        <= '0;
         r_ky        <= '0;
         r_tap       <= '0;
         r_pass      <= '0;
         r_outRow    <= '0;
         r_frameDone <= 1'b0;
      end else begin
         r_frameDone <= 1'b0;
         if (w_pixFire) begin
            r_wrCol <= w_lastCol ? '0 : r_wrCol + COL_W'(1);
            if (w_lastCol) r_wrRow <= (r_wrRow == LAST_KIDX) ? '0 : r_wrRow + ROW_W'(1);
         end
         if (w_enterCompute) begin
            r_kx  <= '0;
            r_ky  <= '0;
            r_tap <= '0;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state  <= S_FILL;
                  r_wrCol  <= '0;
                  r_wrRow  <= '0;
                  r_topRow <= '0;
                  r_pass   <= '0;
                  r_outRow <= '0;
               end
            end
            S_FILL: begin
               if (w_enterCompute) r_state <= S_COMPUTE;
            end
            S_COMPUTE: begin
               if (r_kx == LAST_KIDX) begin
                  r_kx <= '0;
                  r_ky <= r_ky + ROW_W'(1);
               end else begin
                  r_kx <= r_kx + ROW_W'(1);
               end
               r_tap <= r_tap + WADDR_W'(1);
               if (w_lastTap) r_state <= S_EMIT;
            end
            S_EMIT: begin
               if (out_ready) begin
                  if (r_pass != LAST_PASS) begin
                     r_pass  <= r_pass + PASS_W'(1);
                     r_state <= S_COMPUTE;
                  end else if (r_outRow != LAST_OROW) begin
                     r_state <= S_ROW;
                  end else begin
                     r_state     <= S_IDLE;
                     r_frameDone <= 1'b1;
                  end
               end
            end
            S_ROW: begin
               if (w_enterCompute) begin
                  r_state  <= S_COMPUTE;
                  r_topRow <= (r_topRow == LAST_KIDX) ? '0 : r_topRow + ROW_W'(1);
                  r_outRow <= r_outRow + OUT_W'(1);
                  r_pass   <= '0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Circular line buffer: the incoming row always overwrites the oldest stored row
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int r = 0; r < KERNEL_SIZE; r++)
            for (int c = 0; c < IMAGE_SIZE; c++)
               r_lineBuf[r][c] <= '0;
      end else if (w_pixFire) begin
         r_lineBuf[r_wrRow][r_wrCol] <= pixel_in;
      end
   end

   // Weight file: writable at any time except while taps are being consumed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int t = 0; t < TAPS; t++) r_weight[t] <= '0;
      end else if (w_wr_en && (r_state != S_COMPUTE) && (int'(w_addr) < TAPS)) begin
         r_weight[w_addr] <= w_data;
      end
   end

   // Lane accumulators: cleared on pass entry, one tap added per compute cycle
   always_ff @(posedge clk) begin
      if (!rst_n || w_enterCompute) begin
         for (int j = 0; j < ARRAY_SIZE; j++) r_acc[j] <= '0;
      end else if (r_state == S_COMPUTE) begin
         for (int j = 0; j < ARRAY_SIZE; j++) r_acc[j] <= w_accNext[j];
      end
   end

   // Output beat register: captured on the final tap so it is stable throughout EMIT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_outData <= '0;
         r_outMask <= '0;
      end else if ((r_state == S_COMPUTE) && w_lastTap) begin
         for (int j = 0; j < ARRAY_SIZE; j++)
            r_outData[(ARRAY_SIZE-1-j)*WIDTH +: WIDTH] <= w_laneOut[j];
         r_outMask <= w_laneMask;
      end
   end

endmodule

// File: tb/tb_conv_layer_engine.sv
// tb_conv_layer_engine: scoreboard bench for conv_layer_engine (default parameters).
// Stimulus queues pixels and expected beats; a monitor pops and compares each accepted beat.
`timescale 1ns/1ps
module tb_conv_layer_engine;

   localparam int WIDTH = 16;
   localparam int N     = 8;
   localparam int O     = 6;
   localparam int A     = 4;
   localparam int P     = 2;
   localparam int BEATS = O * P;

   localparam int KIND_ONES    = 0;
   localparam int KIND_IDENT   = 1;
   localparam int KIND_SATP    = 2;
   localparam int KIND_SATN    = 3;
   localparam int KIND_SMALL   = 4;
   localparam int KIND_SMALLW0 = 5;

   typedef struct {
      logic [A*WIDTH-1:0] data;
      logic [A-1:0]       mask;
      logic [2:0]         row;
      logic [2:0]         col;
   } beat_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               start;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   pixel_in;
   logic               w_wr_en;
   logic [3:0]         w_addr;
   logic [WIDTH-1:0]   w_data;
   logic               out_valid;
   logic               out_ready;
   logic [A*WIDTH-1:0] out_data;
   logic [A-1:0]       out_mask;
   logic [2:0]         out_row;
   logic [2:0]         out_col;
   logic               busy;
   logic               frame_done;

   beat_t            expQ[$];
   logic [WIDTH-1:0] pixQ[$];
   beat_t            expBeat;
   int               vectors = 0;
   int               miscompares = 0;
   int               beatCount = 0;
   logic             pendingDone = 1'b0;

   conv_layer_engine dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .pixel_in(pixel_in),
      .w_wr_en(w_wr_en), .w_addr(w_addr), .w_data(w_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_mask(out_mask), .out_row(out_row), .out_col(out_col),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] pixVal(input int kind, input int r, input int c);
      case (kind)
         KIND_ONES:  return 16'h0100;
         KIND_IDENT: return 16'((r * 8 + c) << 8);
         KIND_SATP:  return 16'h7FFF;
         KIND_SATN:  return 16'h8000;
         default:    return 16'h0010;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] expVal(input int kind, input int r, input int c);
      case (kind)
         KIND_ONES:  return 16'h0900;
         KIND_IDENT: return 16'(((r + 1) * 8 + c + 1) << 8);
         KIND_SATP:  return 16'h7FFF;
`ifdef CONV_ENGINE_RELU_EN
         KIND_SATN:  return 16'h0000;
`else
         KIND_SATN:  return 16'h8000;
`endif
         KIND_SMALL: return 16'h0090;
         default:    return 16'h087F;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic checkReset(input string name);
      checkOutput(name, 128'({in_ready, out_valid, out_data, out_mask, out_row, out_col, busy, frame_done}), 128'(0));
   endtask

   task automatic writeWeight(input logic [3:0] addr, input logic [WIDTH-1:0] data);
      w_wr_en = 1'b1;
      w_addr  = addr;
      w_data  = data;
      @(posedge clk); #1;
      w_wr_en = 1'b0;
   endtask

   task automatic loadUniform(input logic [WIDTH-1:0] value);
      for (int i = 0; i < 9; i++) writeWeight(4'(i), value);
   endtask

   // Queue a whole frame of pixels and its expected beats, then pulse start
   task automatic applyStimulus(input int kind);
      beat_t b;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            pixQ.push_back(pixVal(kind, r, c));
      for (int r = 0; r < O; r++) begin
         for (int p = 0; p < P; p++) begin
            b.data = '0;
            b.mask = '0;
            b.row  = 3'(r);
            b.col  = 3'(p * A);
            for (int j = 0; j < A; j++) begin
               if (p * A + j < O) begin
                  b.mask[j] = 1'b1;
                  b.data[(A-1-j)*WIDTH +: WIDTH] = expVal(kind, r, p * A + j);
               end
            end
            expQ.push_back(b);
         end
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int cycles;
      cycles = 0;
      while ((expQ.size() > 0) && (cycles < 4000)) begin
         @(posedge clk);
         cycles++;
      end
      #1;
      if (expQ.size() > 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s timeout: %0d beats outstanding, expected 0", name, expQ.size());
         expQ.delete();
         pixQ.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Pixel feeder: presents the queue head and pops it once a transfer has happened
   initial begin
      logic take;
      logic [WIDTH-1:0] dropped;
      in_valid = 1'b0;
      pixel_in = '0;
      forever begin
         @(negedge clk);
         take = in_valid && in_ready;
         @(posedge clk); #1;
         if (take && (pixQ.size() > 0)) dropped = pixQ.pop_front();
         in_valid = (pixQ.size() > 0);
         pixel_in = (pixQ.size() > 0) ? pixQ[0] : '0;
      end
   end

   // Monitor: compares every accepted beat against the scoreboard and checks frame_done
   always @(negedge clk) begin
      if (pendingDone) begin
         pendingDone = 1'b0;
         checkOutput("frame_done/busy after last beat", 128'({frame_done, busy}), 128'(2'b10));
      end
      if (out_valid && out_ready) begin
         beatCount++;
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected beat: got row %0d col %0d, expected no beat", out_row, out_col);
         end else begin
            expBeat = expQ.pop_front();
            checkOutput($sformatf("beat r%0d c%0d", expBeat.row, expBeat.col),
                        128'({out_row, out_col, out_mask, out_data}),
                        128'({expBeat.row, expBeat.col, expBeat.mask, expBeat.data}));
            if (expQ.size() == 0) pendingDone = 1'b1;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int startCount;
      int cyc;
      logic [127:0] snap;
      rst_n     = 1'b0;
      start     = 1'b0;
      w_wr_en   = 1'b0;
      w_addr    = '0;
      w_data    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkReset("reset state");
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] uniform kernel, uniform image");
      loadUniform(16'h0100);
      for (int a = 9; a < 16; a++) writeWeight(4'(a), 16'h7FFF);
      startCount = beatCount;
      applyStimulus(KIND_ONES);
      waitDrain("ones");
      checkOutput("ones beat total", 128'(beatCount - startCount), 128'(BEATS));

      $display("[TB] identity kernel with output backpressure");
      loadUniform(16'h0000);
      writeWeight(4'd4, 16'h0100);
      out_ready = 1'b0;
      startCount = beatCount;
      applyStimulus(KIND_IDENT);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && (cyc < 500));
      checkOutput("first out_valid", 128'(out_valid), 128'(1));
      snap = 128'({1'b1, 1'b0, out_row, out_col, out_mask, out_data});
      repeat (5) begin
         @(negedge clk);
         checkOutput("hold under backpressure",
                     128'({out_valid, in_ready, out_row, out_col, out_mask, out_data}), snap);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("beat taken on first ready", 128'(out_valid), 128'(0));
      waitDrain("identity");
      checkOutput("identity beat total", 128'(beatCount - startCount), 128'(BEATS));

      $display("[TB] saturation");
      loadUniform(16'h7FFF);
      applyStimulus(KIND_SATP);
      waitDrain("sat positive");
      applyStimulus(KIND_SATN);
      waitDrain("sat negative");

      $display("[TB] weight writes during compute and idle");
      loadUniform(16'h0100);
      applyStimulus(KIND_SMALL);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(busy && !in_ready && !out_valid) && (cyc < 500));
      checkOutput("reached compute", 128'(busy && !in_ready && !out_valid), 128'(1));
      w_wr_en = 1'b1;
      w_addr  = 4'd0;
      w_data  = 16'h7FFF;
      @(posedge clk); #1;
      w_wr_en = 1'b0;
      waitDrain("write in compute");
      writeWeight(4'd0, 16'h7FFF);
      applyStimulus(KIND_SMALLW0);
      waitDrain("write in idle");

      $display("[TB] reset during compute of row 3");
      loadUniform(16'h0100);
      applyStimulus(KIND_ONES);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!((out_row == 3'd3) && busy && !in_ready && !out_valid) && (cyc < 3000));
      checkOutput("reached row 3 compute", 128'({out_row, busy, in_ready, out_valid}), 128'({3'd3, 3'b100}));
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkReset("mid-frame reset state");
      expQ.delete();
      pixQ.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      repeat (2) @(posedge clk);
      #1;
      loadUniform(16'h0100);
      startCount = beatCount;
      applyStimulus(KIND_ONES);
      waitDrain("after reset");
      checkOutput("after reset beat total", 128'(beatCount - startCount), 128'(BEATS));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
